fetch_pc_seq: RTL and testbench

FETCH_PC_SEQ -- requirements
Module: fetch_pc_seq

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/rstr_prio_sel.sv | 28 ++
 rtl/fetch_pc_seq.sv | 100 ++++++++++
 tb/tb_fetch_pc_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch PC sequencer.
`default_nettype none

package fetch_pkg;

  localparam int EPOCH_W_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_BUBBLE = 2'd2
  } fetch_state_e;

  typedef logic [EPOCH_W_DEFAULT-1:0] epoch_t;

  // Number of byte-offset bits inside one fetch block.
  function automatic int offset_w(input int fetch_bytes);
    return $clog2(fetch_bytes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rstr_prio_sel.sv
// Fixed-priority resteer arbiter: the lowest-indexed valid source wins.
`default_nettype none

module rstr_prio_sel #(
  parameter int NUM_RSTR = 4,
  parameter int XLEN     = 32
) (
  input  logic [NUM_RSTR-1:0]      rstr_valid,
  input  logic [NUM_RSTR*XLEN-1:0] rstr_target,
  output logic                     any_valid,
  output logic [XLEN-1:0]          sel_target
);

  // Walk from the lowest priority upward so the last hit is the winner.
  always_comb begin
    any_valid  = 1'b0;
    sel_target = '0;
    for (int i = NUM_RSTR - 1; i >= 0; i--) begin
      if (rstr_valid[i]) begin
        any_valid  = 1'b1;
        sel_target = rstr_target[i*XLEN +: XLEN];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_seq.sv
// Fetch PC sequencer: issues block-aligned fetch requests, follows predictions
// and resteers, and tags every request with an epoch.
`default_nettype none

module fetch_pc_seq
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              FETCH_BYTES = 64,
  parameter int              NUM_RSTR    = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              EPOCH_W     = EPOCH_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_in,
  input  logic [NUM_RSTR-1:0]      rstr_valid,
  input  logic [NUM_RSTR*XLEN-1:0] rstr_target,
  input  logic                     bp_taken,
  input  logic [XLEN-1:0]          bp_target,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [XLEN-1:0]          req_addr,
  output logic [EPOCH_W-1:0]       req_epoch,
  output logic [XLEN-1:0]          pc_out,
  output logic [15:0]              rstr_cnt
);

  localparam int              OFF_W    = offset_w(FETCH_BYTES);
  localparam logic [XLEN-1:0] OFF_MASK = (XLEN'(1) << OFF_W) - XLEN'(1);

  fetch_state_e         state, state_n;
  logic [XLEN-1:0]      pc, pc_n;
  logic [EPOCH_W-1:0]   epoch, epoch_n;
  logic [15:0]          cnt, cnt_n;

  logic                 any_rstr;
  logic [XLEN-1:0]      rstr_sel;
  logic                 handshake;

  rstr_prio_sel #(
    .NUM_RSTR (NUM_RSTR),
    .XLEN     (XLEN)
  ) u_prio (
    .rstr_valid  (rstr_valid),
    .rstr_target (rstr_target),
    .any_valid   (any_rstr),
    .sel_target  (rstr_sel)
  );

  assign req_valid = (state == ST_FETCH) && !stall_in;
  assign req_addr  = pc & ~OFF_MASK;
  assign req_epoch = epoch;
  assign pc_out    = pc;
  assign rstr_cnt  = cnt;
  assign handshake = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      epoch <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      epoch <= epoch_n;
      cnt   <= cnt_n;
    end
  end

  // A resteer wins over everything; a handshake in that cycle goes out under
  // the old epoch and is discarded downstream, so pc must not follow it.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    epoch_n = epoch;
    cnt_n   = cnt;
    if (any_rstr) begin
      state_n = ST_BUBBLE;
      pc_n    = rstr_sel;
      epoch_n = epoch + EPOCH_W'(1);
      cnt_n   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    end else begin
      case (state)
        ST_BOOT:   state_n = ST_FETCH;
        ST_BUBBLE: state_n = ST_FETCH;
        ST_FETCH: begin
          if (handshake) begin
            pc_n = bp_taken ? bp_target : req_addr + XLEN'(FETCH_BYTES);
          end
        end
        default:   state_n = ST_BOOT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_seq.sv
// Scoreboard bench for fetch_pc_seq: a reference model predicts each post-edge
// state when stimulus is driven; a monitor pops and compares after the edge.
`default_nettype none

module tb_fetch_pc_seq;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic         clk;
  logic         rst;
  logic         stall_in;
  logic [3:0]   rstr_valid;
  logic [127:0] rstr_target;
  logic         bp_taken;
  logic [31:0]  bp_target;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [1:0]   req_epoch;
  logic [31:0]  pc_out;
  logic [15:0]  rstr_cnt;

  fetch_pc_seq #(
    .XLEN        (32),
    .FETCH_BYTES (64),
    .NUM_RSTR    (4),
    .RESET_PC    (RST_PC),
    .EPOCH_W     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_in    (stall_in),
    .rstr_valid  (rstr_valid),
    .rstr_target (rstr_target),
    .bp_taken    (bp_taken),
    .bp_target   (bp_target),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_epoch   (req_epoch),
    .pc_out      (pc_out),
    .rstr_cnt    (rstr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  ep;
    logic [15:0] cnt;
    logic        v;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: 0 boot, 1 fetch, 2 bubble.
  int          m_state;
  logic [31:0] m_pc;
  logic [1:0]  m_ep;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pc_out",    pc_out,            e.pc);
      check("req_epoch", 32'(req_epoch),    32'(e.ep));
      check("rstr_cnt",  32'(rstr_cnt),     32'(e.cnt));
      check("req_valid", 32'(req_valid),    32'(e.v));
      check("req_addr",  req_addr,          e.addr);
    end
  end

  // Apply the currently driven inputs for one clock and queue the prediction.
  task automatic tick();
    logic v_now, hs;
    exp_t x;
    v_now = (m_state == 1) && !stall_in;
    hs    = v_now && req_ready;
    if (rst) begin
      m_state = 0; m_pc = RST_PC; m_ep = 2'd0; m_cnt = 16'd0;
    end else if (rstr_valid != 4'b0) begin
      for (int i = 3; i >= 0; i--)
        if (rstr_valid[i]) m_pc = rstr_target[i*32 +: 32];
      m_ep    = m_ep + 2'd1;
      m_cnt   = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      m_state = 2;
    end else if (m_state != 1) begin
      m_state = 1;
    end else if (hs) begin
      m_pc = bp_taken ? bp_target : (m_pc & ~32'h3F) + 32'd64;
    end
    x.pc   = m_pc;
    x.ep   = m_ep;
    x.cnt  = m_cnt;
    x.v    = (m_state == 1) && !stall_in;
    x.addr = m_pc & ~32'h3F;
    sb.push_back(x);
    #1;
    check("valid_pre", 32'(req_valid), 32'(v_now));
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall_in = 1'b0; rstr_valid = 4'b0; bp_taken = 1'b0;
    bp_target = 32'h0; req_ready = 1'b1;
  endtask

  initial begin
    m_state = 0; m_pc = RST_PC; m_ep = 2'd0; m_cnt = 16'd0;
    idle_inputs();
    rstr_target = '0;
    rst = 1'b1;
    @(posedge clk); #2;
    tick(); tick();

    // Boot then sequential blocks 0x100, 0x140, 0x180.
    rst = 1'b0;
    tick(); tick(); tick();

    // Two resteers at once: source 1 beats source 2.
    rstr_valid = 4'b0110;
    rstr_target[1*32 +: 32] = 32'h0000_2004;
    rstr_target[2*32 +: 32] = 32'h0000_3000;
    tick();
    rstr_valid = 4'b0;
    tick(); tick();

    // Predicted redirect, then a prediction without a handshake.
    bp_taken = 1'b1; bp_target = 32'h0000_5010;
    tick();
    req_ready = 1'b0; bp_target = 32'h0000_9990;
    tick();
    idle_inputs();

    // Stall holds; a resteer during stall still lands.
    stall_in = 1'b1;
    tick(); tick(); tick();
    rstr_valid = 4'b1000; rstr_target[3*32 +: 32] = 32'h0000_7000;
    tick();
    rstr_valid = 4'b0;
    tick();
    stall_in = 1'b0;
    tick();

    // Address wrap at the top of the space, then epoch wrap.
    rstr_valid = 4'b0001; rstr_target[31:0] = 32'hFFFF_FFC0;
    tick();
    rstr_valid = 4'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      rstr_valid = 4'b0100; rstr_target[2*32 +: 32] = 32'h0000_1000 + 32'(i * 4);
      tick();
    end
    rstr_valid = 4'b0;
    tick();

    // Handshake plus resteer: request still presented, pc follows the resteer.
    rstr_valid = 4'b0001; rstr_target[31:0] = 32'h0000_4440;
    tick();
    rstr_valid = 4'b0;
    tick(); tick();

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      stall_in   = ($urandom_range(0, 3) == 0);
      req_ready  = ($urandom_range(0, 3) != 0);
      rstr_valid = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
      for (int k = 0; k < 4; k++) rstr_target[k*32 +: 32] = $urandom;
      bp_taken   = $urandom_range(0, 1) == 1;
      bp_target  = $urandom;
      tick();
    end

    // Reset in FETCH together with a resteer and a handshake.
    idle_inputs();
    tick(); tick();
    rst = 1'b1; rstr_valid = 4'b0001; rstr_target[31:0] = 32'h0000_8880;
    bp_taken = 1'b1; bp_target = 32'h0000_9000;
    tick();
    idle_inputs();
    tick();

    @(posedge clk); #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
